// File: rtl/d3s_phase_to_square_if.sv
// Phase-in / square-wave-out bundle between the divider stage and d3s_phase_to_square.
interface d3s_phase_to_square_if;
    logic [55:0] phase_i;
    logic        phase_valid_i;
    logic        enable_i;
    logic        clear_err_i;
    logic [3:0]  sq_o;
    logic        sq_valid_o;
    logic [31:0] edge_count_o;
    logic [15:0] period_o;
    logic        period_err_o;
    logic        dropout_err_o;

    modport master (
        output phase_i, phase_valid_i, enable_i, clear_err_i,
        input  sq_o, sq_valid_o, edge_count_o, period_o, period_err_o, dropout_err_o
    );

    modport slave (
        input  phase_i, phase_valid_i, enable_i, clear_err_i,
        output sq_o, sq_valid_o, edge_count_o, period_o, period_err_o, dropout_err_o
    );
endinterface

// File: rtl/d3s_phase_to_square.sv
// Turns four divided-phase sub-samples per cycle into a runt-free 4-bit square word,
// counting emitted rising edges and monitoring the rise-to-rise period.
module d3s_phase_to_square #(
    parameter int unsigned g_min_period = 8,
    parameter int unsigned g_max_period = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    d3s_phase_to_square_if.slave  bus
);
    localparam logic [15:0] lp_min_period = 16'(g_min_period);
    localparam logic [15:0] lp_max_period = 16'(g_max_period);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUNNING, S_STOPPING} state_t;

    // Bits at and above the lowest set bit of x.
    function automatic logic [3:0] from_lowest(input logic [3:0] x);
        return {|x, |x[2:0], |x[1:0], x[0]};
    endfunction

    logic [3:0] b_now, rise_now, fall_now;
    logic       p_q;
    logic [3:0] b1_q, rise1_q, fall1_q;
    logic       valid1_q, en1_q;

    state_t      state_q, state_d;
    logic [3:0]  sq_q, sq_d, sq_rise;
    logic        emit, valid_q, dropout_set;
    logic [31:0] edge_q;
    logic [15:0] cnt_q, acc, period_q, period_d;
    logic        started_q, started_d, tmo_q, tmo_d, perr_set;
    logic [1:0]  n_rise;
    logic        perr_q, derr_q;
    logic        phase_lsbs_unused;

    assign b_now    = {bus.phase_i[55], bus.phase_i[41], bus.phase_i[27], bus.phase_i[13]};
    assign rise_now = b_now & ~{b_now[2:0], p_q};
    assign fall_now = ~b_now & {b_now[2:0], p_q};
    assign phase_lsbs_unused = ^{bus.phase_i[54:42], bus.phase_i[40:28],
                                 bus.phase_i[26:14], bus.phase_i[12:0]};

    // Stage 1; enable travels with its word so both reach the FSM together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q      <= 1'b0;
            b1_q     <= '0;
            rise1_q  <= '0;
            fall1_q  <= '0;
            valid1_q <= 1'b0;
            en1_q    <= 1'b0;
        end else begin
            p_q      <= bus.phase_valid_i & b_now[3];
            b1_q     <= b_now;
            rise1_q  <= bus.phase_valid_i ? rise_now : '0;
            fall1_q  <= bus.phase_valid_i ? fall_now : '0;
            valid1_q <= bus.phase_valid_i;
            en1_q    <= bus.enable_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        sq_d        = '0;
        emit        = 1'b0;
        dropout_set = 1'b0;
        if (!valid1_q) begin
            state_d     = en1_q ? S_ARMED : S_IDLE;
            dropout_set = (state_q == S_RUNNING) || (state_q == S_STOPPING);
        end else begin
            case (state_q)
                S_IDLE: if (en1_q) state_d = S_ARMED;
                S_ARMED: begin
                    if (!en1_q) begin
                        state_d = S_IDLE;
                    end else if (|rise1_q) begin
                        sq_d    = b1_q & from_lowest(rise1_q);
                        emit    = 1'b1;
                        state_d = S_RUNNING;
                    end
                end
                S_RUNNING: begin
                    sq_d = b1_q;
                    emit = 1'b1;
                    if (!en1_q) state_d = (!b1_q[3] && !(|rise1_q)) ? S_IDLE : S_STOPPING;
                end
                S_STOPPING: begin
                    emit = 1'b1;
                    if (en1_q) begin
                        sq_d    = b1_q;
                        state_d = S_RUNNING;
                    end else if (|fall1_q) begin
                        sq_d    = b1_q & ~from_lowest(fall1_q);
                        state_d = S_IDLE;
                    end else begin
                        sq_d = b1_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign sq_rise = sq_d & ~{sq_d[2:0], sq_q[3]};

    // acc walks sub-sample by sub-sample: distance since the last emitted rise.
    always_comb begin
        acc       = cnt_q;
        started_d = started_q;
        tmo_d     = tmo_q;
        period_d  = period_q;
        perr_set  = 1'b0;
        n_rise    = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (sq_rise[k]) begin
                n_rise = n_rise + 2'd1;
                if (started_d) begin
                    period_d = acc;
                    if (acc < lp_min_period || acc > lp_max_period) perr_set = 1'b1;
                end
                acc       = '0;
                started_d = 1'b1;
                tmo_d     = 1'b0;
            end
            if (acc != 16'hFFFF) acc = acc + 16'd1;
        end
        if (started_d && !tmo_d && acc > lp_max_period) begin
            perr_set = 1'b1;
            tmo_d    = 1'b1;
        end
        if (!emit) begin
            acc       = '0;
            started_d = 1'b0;
            tmo_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            sq_q      <= '0;
            valid_q   <= 1'b0;
            edge_q    <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            started_q <= 1'b0;
            tmo_q     <= 1'b0;
            perr_q    <= 1'b0;
            derr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sq_q      <= sq_d;
            valid_q   <= emit;
            edge_q    <= edge_q + 32'(n_rise);
            cnt_q     <= acc;
            period_q  <= period_d;
            started_q <= started_d;
            tmo_q     <= tmo_d;
            perr_q    <= perr_set | (perr_q & ~bus.clear_err_i);
            derr_q    <= dropout_set | (derr_q & ~bus.clear_err_i);
        end
    end

    assign bus.sq_o          = sq_q;
    assign bus.sq_valid_o    = valid_q;
    assign bus.edge_count_o  = edge_q;
    assign bus.period_o      = period_q;
    assign bus.period_err_o  = perr_q;
    assign bus.dropout_err_o = derr_q;
endmodule

// File: tb/tb_d3s_phase_to_square.sv
// Directed self-checking bench for d3s_phase_to_square; word driven in one slot appears two slots later.
module tb_d3s_phase_to_square;
    logic clk_i = 1'b0;
    logic rst_i;
    always #4 clk_i = ~clk_i;

    d3s_phase_to_square_if bus ();

    d3s_phase_to_square #(
        .g_min_period(8),
        .g_max_period(64)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [13:0] ph;

    // Expected outputs for ramp words c0..c20 (period 10, enable 5..15).
    logic [3:0] exp_sq  [21] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hC, 4'h7, 4'h0, 4'hF, 4'h1,
                                 4'hC, 4'h7, 4'h0, 4'hF, 4'h1, 4'hC, 4'h7, 4'h0, 4'h0, 4'h0};
    logic       exp_v   [21] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    int         exp_ec  [21] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 3, 3, 3, 4, 4, 5, 5, 5, 5, 5};
    int         exp_per [21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_ramp(input logic [13:0] step, input logic en, input logic clr);
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 4; k++) begin
            bus.phase_i[14*k +: 14] = ph;
            ph = ph + step;
        end
        bus.phase_valid_i = 1'b1;
        bus.enable_i      = en;
        bus.clear_err_i   = clr;
    endtask

    task automatic tick_bits(input logic [3:0] bits, input logic valid, input logic en, input logic clr);
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 4; k++) bus.phase_i[14*k +: 14] = bits[k] ? 14'h3000 : 14'h1000;
        bus.phase_valid_i = valid;
        bus.enable_i      = en;
        bus.clear_err_i   = clr;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] sq, input logic v, input int ec, input int per);
        chk({tag, "_sq"},     32'(bus.sq_o),         32'(sq));
        chk({tag, "_valid"},  32'(bus.sq_valid_o),   32'(v));
        chk({tag, "_edges"},  bus.edge_count_o,      32'(ec));
        chk({tag, "_period"}, 32'(bus.period_o),     32'(per));
    endtask

    initial begin
        rst_i             = 1'b1;
        ph                = '0;
        bus.phase_i       = '0;
        bus.phase_valid_i = 1'b0;
        bus.enable_i      = 1'b0;
        bus.clear_err_i   = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_out("reset", 4'h0, 1'b0, 0, 0);
        chk("reset_perr", 32'(bus.period_err_o), 32'd0);
        chk("reset_derr", 32'(bus.dropout_err_o), 32'd0);
        rst_i = 1'b0;

        // Ramp period 10; enable 5..15, then dropped mid-high-phase at word 16.
        for (int s = 0; s < 23; s++) begin
            tick_ramp(14'd1638, (s >= 5 && s < 16), 1'b0);
            if (s >= 2) chk_out($sformatf("ramp10_w%0d", s - 2), exp_sq[s-2], exp_v[s-2], exp_ec[s-2], exp_per[s-2]);
        end
        chk("ramp10_perr", 32'(bus.period_err_o), 32'd0);
        chk("ramp10_derr", 32'(bus.dropout_err_o), 32'd0);

        // Period-4 ramp: every word 1001, clear coincident with the first error.
        ph = 14'd12288;
        tick_ramp(14'd4096, 1'b1, 1'b0);
        tick_ramp(14'd4096, 1'b1, 1'b0);
        tick_ramp(14'd4096, 1'b1, 1'b0);
        chk_out("p4_armed", 4'h0, 1'b0, 5, 10);
        tick_ramp(14'd4096, 1'b1, 1'b1);
        chk_out("p4_first_masked", 4'h8, 1'b1, 6, 10);
        chk("p4_first_perr", 32'(bus.period_err_o), 32'd0);
        tick_ramp(14'd4096, 1'b0, 1'b0);
        chk_out("p4_second", 4'h9, 1'b1, 7, 4);
        chk("p4_set_beats_clear", 32'(bus.period_err_o), 32'd1);
        tick_ramp(14'd4096, 1'b0, 1'b0);
        chk_out("p4_third", 4'h9, 1'b1, 8, 4);
        tick_ramp(14'd4096, 1'b0, 1'b0);
        chk_out("p4_stopping", 4'h9, 1'b1, 9, 4);
        tick_ramp(14'd4096, 1'b0, 1'b0);
        chk_out("p4_fall_masked", 4'h1, 1'b1, 9, 4);
        tick_ramp(14'd4096, 1'b0, 1'b1);
        chk_out("p4_idle", 4'h0, 1'b0, 9, 4);
        tick_ramp(14'd4096, 1'b0, 1'b0);
        chk("p4_cleared", 32'(bus.period_err_o), 32'd0);

        // Constant phase: stays ARMED without timeout.
        repeat (30) tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        chk_out("const_armed", 4'h0, 1'b0, 9, 4);
        chk("const_no_timeout", 32'(bus.period_err_o), 32'd0);

        // Single pulse then silence: 15 empty words reach 64, the 16th exceeds it.
        tick_bits(4'h1, 1'b1, 1'b1, 1'b0);
        tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        chk_out("tmo_pulse", 4'h1, 1'b1, 10, 4);
        repeat (15) tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        chk("tmo_at_64", 32'(bus.period_err_o), 32'd0);
        tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        chk("tmo_at_68", 32'(bus.period_err_o), 32'd1);
        tick_bits(4'h0, 1'b1, 1'b1, 1'b1);
        tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        chk("tmo_cleared", 32'(bus.period_err_o), 32'd0);
        chk("tmo_running_valid", 32'(bus.sq_valid_o), 32'd1);
        tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        chk("tmo_fires_once", 32'(bus.period_err_o), 32'd0);
        tick_bits(4'h0, 1'b1, 1'b0, 1'b0);
        tick_bits(4'h0, 1'b1, 1'b0, 1'b0);
        tick_bits(4'h0, 1'b1, 1'b0, 1'b0);
        tick_bits(4'h0, 1'b1, 1'b0, 1'b0);
        chk("tmo_stopped_valid", 32'(bus.sq_valid_o), 32'd0);

        // Dropout while RUNNING, then re-arm on the next rise.
        tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        tick_bits(4'hF, 1'b1, 1'b1, 1'b0);
        tick_bits(4'hF, 1'b0, 1'b1, 1'b0);
        tick_bits(4'hF, 1'b1, 1'b1, 1'b0);
        chk_out("drop_before", 4'hF, 1'b1, 11, 4);
        chk("drop_before_derr", 32'(bus.dropout_err_o), 32'd0);
        tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        chk_out("drop_word", 4'h0, 1'b0, 11, 4);
        chk("drop_derr", 32'(bus.dropout_err_o), 32'd1);
        tick_bits(4'hF, 1'b1, 1'b1, 1'b0);
        chk_out("drop_rearm", 4'hF, 1'b1, 12, 4);
        tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        chk_out("drop_gap", 4'h0, 1'b1, 12, 4);
        tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        chk_out("drop_period_min", 4'hF, 1'b1, 13, 8);
        chk("drop_period_min_perr", 32'(bus.period_err_o), 32'd0);

        // Reset for one cycle mid-run.
        tick_bits(4'hF, 1'b1, 1'b1, 1'b0);
        rst_i = 1'b1;
        tick_bits(4'hF, 1'b1, 1'b1, 1'b0);
        rst_i = 1'b0;
        chk_out("rst_mid", 4'h0, 1'b0, 0, 0);
        chk("rst_mid_perr", 32'(bus.period_err_o), 32'd0);
        chk("rst_mid_derr", 32'(bus.dropout_err_o), 32'd0);
        tick_bits(4'hF, 1'b1, 1'b1, 1'b0);
        chk_out("rst_after1", 4'h0, 1'b0, 0, 0);
        chk("rst_after1_derr", 32'(bus.dropout_err_o), 32'd0);
        tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        tick_bits(4'hF, 1'b1, 1'b1, 1'b0);
        chk_out("rst_idle_no_emit", 4'h0, 1'b0, 0, 0);
        tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        tick_bits(4'h0, 1'b1, 1'b1, 1'b0);
        chk_out("rst_first_rise", 4'hF, 1'b1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
